// File: rtl/alu_op_sequencer.sv
// Handshaked command front end for the 8-bit ALU: decodes opcode to one-hot strobes, holds operands, returns result.
// Optional ALU_SEQ_FLAGS_EN adds captured rsp_zero / rsp_neg outputs.
//
// state | meaning
// IDLE  | ready for a request, strobes low
// DRIVE | one strobe high, operands held, hold counter running
// RESP  | result captured, rsp_valid high until consumed
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int SHIFT_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   input  logic       req_shift,
   output logic [7:0] alu_A,
   output logic [7:0] alu_B,
   output logic       alu_a,
   output logic       alu_s,
   output logic       alu_m,
   output logic       alu_sh,
   output logic       alu_o,
   output logic       alu_n,
   output logic       alu_x,
   output logic       alu_nan,
   output logic       alu_shift,
   input  logic [7:0] alu_O,
   input  logic       alu_Cout,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_result,
   output logic       rsp_cout,
`ifdef ALU_SEQ_FLAGS_EN
   output logic       rsp_zero,
   output logic       rsp_neg,
`endif
   output logic [2:0] rsp_op
);

   localparam int CW      = 16;
   localparam int SETTLE_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int SHIFT_N  = (SHIFT_CYCLES < 1) ? 1 : SHIFT_CYCLES;
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_N);
   localparam logic [CW-1:0] SHIFT_LD  = CW'(SHIFT_N);

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_SHIFT = 3'd3;

   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_q;
   logic [7:0]      strobe;

   assign req_ready = (state == IDLE) && !rst;

   assign {alu_nan, alu_x, alu_n, alu_o, alu_sh, alu_m, alu_s, alu_a} = strobe;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         op_q       <= '0;
         strobe     <= '0;
         alu_A      <= '0;
         alu_B      <= '0;
         alu_shift  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_cout   <= 1'b0;
         rsp_op     <= '0;
`ifdef ALU_SEQ_FLAGS_EN
         rsp_zero   <= 1'b0;
         rsp_neg    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  alu_A     <= req_a;
                  alu_B     <= req_b;
                  alu_shift <= req_shift;
                  op_q      <= req_op;
                  strobe    <= 8'b1 << req_op;
                  cnt       <= (req_op == OP_SHIFT) ? SHIFT_LD : SETTLE_LD;
                  state     <= DRIVE;
               end
            end
            DRIVE: begin
               // last hold cycle: ALU output has settled for the full window
               if (cnt == CW'(1)) begin
                  strobe     <= '0;
                  rsp_result <= alu_O;
                  rsp_cout   <= ((op_q == OP_ADD) || (op_q == OP_SUB)) && alu_Cout;
                  rsp_op     <= op_q;
                  rsp_valid  <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                  rsp_zero   <= (alu_O == 8'h00);
                  rsp_neg    <= alu_O[7];
`endif
                  state      <= RESP;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, arithmetic reference, directed + random ops.
// Define ALU_SEQ_FLAGS_EN to also check rsp_zero / rsp_neg.
module tb_alu_op_sequencer;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       req_shift;
   logic [7:0] alu_A;
   logic [7:0] alu_B;
   logic       alu_a, alu_s, alu_m, alu_sh, alu_o, alu_n, alu_x, alu_nan;
   logic       alu_shift;
   logic [7:0] alu_O;
   logic       alu_Cout;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_result;
   logic       rsp_cout;
   logic [2:0] rsp_op;
`ifdef ALU_SEQ_FLAGS_EN
   logic       rsp_zero;
   logic       rsp_neg;
`endif

   logic [7:0]  strobes;
   logic [15:0] prod;
   int total = 0;
   int bad   = 0;

   alu_op_sequencer #(.SETTLE_CYCLES(1), .SHIFT_CYCLES(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
      .alu_A(alu_A), .alu_B(alu_B),
      .alu_a(alu_a), .alu_s(alu_s), .alu_m(alu_m), .alu_sh(alu_sh),
      .alu_o(alu_o), .alu_n(alu_n), .alu_x(alu_x), .alu_nan(alu_nan),
      .alu_shift(alu_shift), .alu_O(alu_O), .alu_Cout(alu_Cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_cout(rsp_cout),
`ifdef ALU_SEQ_FLAGS_EN
      .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
      .rsp_op(rsp_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign strobes = {alu_nan, alu_x, alu_n, alu_o, alu_sh, alu_m, alu_s, alu_a};

   // behavioural ALU; carry output is deliberately nonzero for some logic ops so masking is visible
   always_comb begin
      alu_O    = 8'h00;
      alu_Cout = 1'b0;
      prod     = 16'(alu_A) * 16'(alu_B);
      if (alu_a) {alu_Cout, alu_O} = {1'b0, alu_A} + {1'b0, alu_B};
      else if (alu_s) begin
         alu_O    = alu_A - alu_B;
         alu_Cout = (alu_A < alu_B);
      end else if (alu_m) begin
         alu_O    = prod[7:0];
         alu_Cout = |prod[15:8];
      end else if (alu_sh) begin
         alu_O    = alu_shift ? {alu_A[6:0], 1'b0} : {1'b0, alu_A[7:1]};
         alu_Cout = alu_shift ? alu_A[7] : alu_A[0];
      end else if (alu_o) alu_O = alu_A | alu_B;
      else if (alu_n) begin
         alu_O    = ~alu_A;
         alu_Cout = 1'b1;
      end else if (alu_x) alu_O = alu_A ^ alu_B;
      else if (alu_nan) begin
         alu_O    = ~(alu_A & alu_B);
         alu_Cout = 1'b1;
      end
   end

   // reference: {cout, result} from the opcode meaning, plain integer arithmetic
   function automatic logic [8:0] ref_op(input int op, input int a, input int b, input int sh);
      int r;
      int c;
      c = 0;
      case (op)
         0: begin r = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
         1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
         2: r = (a * b) % 256;
         3: r = (sh != 0) ? (a * 2) % 256 : a / 2;
         4: r = a | b;
         5: r = 255 - a;
         6: r = a ^ b;
         default: r = 255 - (a & b);
      endcase
      return {c[0], r[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // entered and left at a negedge with the sequencer idle
   task automatic run_op(input int op, input int a, input int b, input int sh, input int hold);
      logic [8:0] r;
      int n;
      int cyc;
      r = ref_op(op, a, b, sh);
      n = (op == 3) ? 2 : 1;
      chk("idle_ready", req_ready, 1);
      req_valid = 1'b1;
      req_op    = 3'(op);
      req_a     = 8'(a);
      req_b     = 8'(b);
      req_shift = 1'(sh);
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 3'($urandom);
      req_a     = 8'($urandom);
      req_b     = 8'($urandom);
      req_shift = 1'($urandom);
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         chk("drive_strobe", strobes, 32'h1 << op);
         chk("drive_ready", req_ready, 0);
         chk("drive_opa", alu_A, a);
         if (op == 3) chk("drive_shctl", alu_shift, sh);
         else if (op != 5) chk("drive_opb", alu_B, b);
         cyc++;
         @(negedge clk);
         req_valid = 1'($urandom_range(0, 1));
      end
      chk("latency", cyc, n);
      for (int i = 0; i <= hold; i++) begin
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_result", rsp_result, r[7:0]);
         chk("rsp_cout", rsp_cout, r[8]);
         chk("rsp_op", rsp_op, op);
         chk("rsp_strobes", strobes, 0);
         chk("rsp_ready_low", req_ready, 0);
         chk("rsp_opa_hold", alu_A, a);
`ifdef ALU_SEQ_FLAGS_EN
         chk("rsp_zero", rsp_zero, (r[7:0] == 8'h00));
         chk("rsp_neg", rsp_neg, r[7]);
`endif
         rsp_ready = (i == hold);
         if (i == hold) req_valid = 1'b0;
         @(negedge clk);
         if (i != hold) req_valid = 1'($urandom_range(0, 1));
      end
      rsp_ready = 1'b0;
      chk("hs_valid_clear", rsp_valid, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = '0; req_a = '0; req_b = '0; req_shift = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_strobes", strobes, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_cout", rsp_cout, 0);
      chk("rst_op", rsp_op, 0);
      chk("rst_opa", alu_A, 0);
      chk("rst_opb", alu_B, 0);
      chk("rst_shctl", alu_shift, 0);
`ifdef ALU_SEQ_FLAGS_EN
      chk("rst_zero", rsp_zero, 0);
      chk("rst_neg", rsp_neg, 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      run_op(0, 8'hF0, 8'h20, 0, 0);
      run_op(2, 8'h12, 8'h10, 0, 1);
      run_op(3, 8'h81, 8'h00, 1, 0);
      run_op(3, 8'h81, 8'h00, 0, 2);
      run_op(6, 8'h5A, 8'hFF, 0, 5);
      run_op(1, 8'h10, 8'h20, 0, 0);
      run_op(7, 8'hF0, 8'h3C, 0, 0);
      run_op(6, 8'h5A, 8'h5A, 0, 0);
      run_op(5, 8'h01, 8'h77, 0, 1);
      run_op(4, 8'h81, 8'h18, 0, 0);

      // reset while driving a two-cycle shift
      req_valid = 1'b1; req_op = 3'd3; req_a = 8'hC3; req_b = 8'h00; req_shift = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_pre_strobe", strobes, 8'h08);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_strobes", strobes, 0);
      chk("abort_valid", rsp_valid, 0);
      chk("abort_ready_rst", req_ready, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", rsp_valid, 0);
      end
      run_op(7, 8'hAA, 8'h0F, 0, 0);

      // reset while a response is pending
      req_valid = 1'b1; req_op = 3'd0; req_a = 8'h7F; req_b = 8'h01; req_shift = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("resp_abort_reached", rsp_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("resp_abort_valid", rsp_valid, 0);
      chk("resp_abort_result", rsp_result, 0);
      rst = 1'b0;
      @(negedge clk);
      run_op(1, 8'h05, 8'h03, 0, 0);

      for (int k = 0; k < 60; k++)
         run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side front end for the 8-bit ALU datapath. It accepts encoded operation requests over a valid/ready handshake and decodes each opcode into the ALU's one-hot operation strobes. It drives and holds the operands for the required settle time, then captures the ALU result and carry and returns them over a second valid/ready handshake. It sits between any requester (test sequencer, future controller) and the ALU, which has no handshake of its own.

## Interface
Parameters:
- SETTLE_CYCLES, 1, cycles strobes/operands are held for combinational ops (add, sub, mul, or, not, xor, nand); values <1 behave as 1.
- SHIFT_CYCLES, 2, cycles held for the clocked shift op; values <1 behave as 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  opcode: 0 add, 1 sub, 2 mul, 3 shift, 4 or, 5 not, 6 xor, 7 nand.
- req_a  in  8  operand A.
- req_b  in  8  operand B (ignored for shift and not).
- req_shift  in  1  shift direction/control, forwarded for op 3.
- alu_A, alu_B  out  8 each  registered operands to ALU.
- alu_a, alu_s, alu_m, alu_sh, alu_o, alu_n, alu_x, alu_nan  out  1 each  one-hot op strobes.
- alu_shift  out  1  registered shift control.
- alu_O  in  8  ALU result.
- alu_Cout  in  1  ALU carry/borrow.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  8  captured alu_O.
- rsp_cout  out  1  captured alu_Cout for ops 0/1, else 0.
- rsp_op  out  3  opcode of this response.

## Operation
- FSM states: IDLE, DRIVE, RESP.
- IDLE: req_ready=1. On req_valid&req_ready: register req_a/req_b/req_shift/req_op, load hold counter with N (SHIFT_CYCLES for op 3, else SETTLE_CYCLES), go DRIVE.
- DRIVE: exactly one strobe high, matching the registered opcode; operands stable. Counter decrements each cycle. On the last cycle (counter==1), capture alu_O into rsp_result and alu_Cout (masked) into rsp_cout, then go RESP.
- RESP: all strobes 0; operands hold last value; rsp_valid=1 with stable payload until rsp_ready. On rsp_valid&rsp_ready, go IDLE.
- Requests are never accepted outside IDLE. req_ready is low in DRIVE/RESP and during rst.
- Only the low 8 bits of the multiply are returned. No wider arithmetic in this block.
- Strobes are never more than one-hot. They are all zero outside DRIVE.

## Timing
- Reset (rst high at an edge): state IDLE. alu_A, alu_B, alu_shift, all strobes, rsp_valid, rsp_result, rsp_cout and rsp_op are 0. req_ready reads 0 while rst is high.
- Reset mid-DRIVE or mid-RESP aborts. Strobes and rsp_valid are 0 after that edge. No response is produced for the aborted request.
- Accept at edge t0. Strobes are high for cycles t0+1 … t0+N. Capture happens at edge t0+N. rsp_valid is high from t0+N onward.
- Latency accept→rsp_valid is N cycles. Earliest next accept is one cycle after the response handshake edge, because the sequencer must return to IDLE first. Throughput is at most 1 op per N+2 cycles.
- rsp_ready held low: rsp_valid and the payload stay constant indefinitely, and req_ready stays 0.
- req_valid changes while the sequencer is not ready are ignored. The payload is sampled only at the accept edge.

## Configuration
- ALU_SEQ_FLAGS_EN defined: adds outputs rsp_zero (1 bit, captured alu_O==0) and rsp_neg (1 bit, captured alu_O[7]). Both are captured with rsp_result and reset to 0.
- Undefined: those ports and their registers are absent. All other behaviour is identical.

## Test plan
All scenarios use a behavioural ALU model on the bench, with SETTLE_CYCLES=1 and SHIFT_CYCLES=2 unless stated.
- Add: op 0, A=0xF0, B=0x20 accepted at t0 → alu_a high only at cycle t0+1; rsp_valid from t0+1; rsp_result=0x10; rsp_cout=1.
- Mul: op 2, A=0x12, B=0x10 → rsp_result=0x20; rsp_cout=0; alu_m is the only strobe seen.
- Shift: op 3, A=0x81, req_shift=1 → alu_sh high for exactly 2 cycles; capture at t0+2; rsp_op=3.
- Backpressure: xor 0x5A^0xFF with rsp_ready low for 5 cycles → rsp_result=0xA5 stable and req_ready=0 throughout; a new request is accepted only after the handshake plus 1 cycle.
- Reset mid-op: SETTLE_CYCLES=4, accept nand, assert rst at t0+2 → all strobes 0 and rsp_valid never rises; the next request completes normally.
- With ALU_SEQ_FLAGS_EN: xor 0x5A^0x5A → rsp_result=0x00, rsp_zero=1, rsp_neg=0. Not on A=0x01 → rsp_result=0xFE, rsp_neg=1.
